// File: rtl/datapath_multiciclo.sv
`timescale 1ns/1ps
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared
// req/ready memory port, with internal register file, ALU and illegal-instruction flag.
module datapath_multiciclo #(
  parameter int                DATA_W = 32,
  parameter int                NREG   = 32,
  parameter logic [DATA_W-1:0] PC_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc_o,
  output logic [2:0]        state_o,
  output logic              illegal_o
);

  localparam int RI = $clog2(NREG);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  state_t            state_reg;
  logic [DATA_W-1:0] pc_reg, a_reg, b_reg, aluout_reg, mdr_reg;
  logic [31:0]       ir_reg;
  logic [DATA_W-1:0] rf_reg [NREG];

  logic [5:0]        op, funct;
  logic [RI-1:0]     rs_idx, rt_idx, rd_idx, wb_idx;
  logic [DATA_W-1:0] imm_sext, br_target, j_target, alu_r, wb_data;
  logic              op_known, funct_known;
  logic              unused_ir;

  assign op        = ir_reg[31:26];
  assign funct     = ir_reg[5:0];
  assign rs_idx    = ir_reg[21 +: RI];
  assign rt_idx    = ir_reg[16 +: RI];
  assign rd_idx    = ir_reg[11 +: RI];
  assign imm_sext  = {{(DATA_W-16){ir_reg[15]}}, ir_reg[15:0]};
  assign br_target = pc_reg + (imm_sext << 2);
  assign j_target  = {pc_reg[DATA_W-1:28], ir_reg[25:0], 2'b00};
  assign wb_idx    = (op == OP_R) ? rd_idx : rt_idx;
  assign wb_data   = (op == OP_LW) ? mdr_reg : aluout_reg;
  assign unused_ir = ^ir_reg[10:6];

  always_comb begin
    alu_r       = '0;
    funct_known = 1'b1;
    case (funct)
      F_ADD:   alu_r = a_reg + b_reg;
      F_SUB:   alu_r = a_reg - b_reg;
      F_AND:   alu_r = a_reg & b_reg;
      F_OR:    alu_r = a_reg | b_reg;
      F_SLT:   alu_r = {{(DATA_W-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
      default: funct_known = 1'b0;
    endcase
  end

  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_known = 1'b1;
      default:                                   op_known = 1'b0;
    endcase
  end

  // Memory strobes are gated by rst_n so an in-flight access drops the moment reset asserts.
  assign mem_req   = rst_n && ((state_reg == FETCH) || (state_reg == MEM));
  assign mem_we    = rst_n && (state_reg == MEM) && (op == OP_SW);
  assign mem_addr  = !rst_n ? '0 : ((state_reg == MEM) ? aluout_reg : pc_reg);
  assign mem_wdata = rst_n ? b_reg : '0;
  assign pc_o      = pc_reg;
  assign state_o   = state_reg;
  assign illegal_o = ((state_reg == DECODE) && !op_known) ||
                     ((state_reg == EXEC) && (op == OP_R) && !funct_known);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FETCH;
      pc_reg     <= PC_RST;
      ir_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      aluout_reg <= '0;
      mdr_reg    <= '0;
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (mem_ready) begin
            ir_reg    <= mem_rdata[31:0];
            pc_reg    <= pc_reg + DATA_W'(4);
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          a_reg      <= rf_reg[rs_idx];
          b_reg      <= rf_reg[rt_idx];
          aluout_reg <= br_target;
          case (op)
            OP_J: begin
              pc_reg    <= j_target;
              state_reg <= FETCH;
            end
            OP_R, OP_BEQ, OP_ADDI, OP_LW, OP_SW: state_reg <= EXEC;
            default:                             state_reg <= FETCH;
          endcase
        end
        EXEC: begin
          case (op)
            OP_R: begin
              if (funct_known) begin
                aluout_reg <= alu_r;
                state_reg  <= WB;
              end else begin
                state_reg  <= FETCH;
              end
            end
            OP_LW, OP_SW: begin
              aluout_reg <= a_reg + imm_sext;
              state_reg  <= MEM;
            end
            OP_ADDI: begin
              aluout_reg <= a_reg + imm_sext;
              state_reg  <= WB;
            end
            OP_BEQ: begin
              // aluout_reg still holds the branch target computed in DECODE
              if (a_reg == b_reg) pc_reg <= aluout_reg;
              state_reg <= FETCH;
            end
            default: state_reg <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (op == OP_LW) begin
              mdr_reg   <= mem_rdata;
              state_reg <= WB;
            end else begin
              state_reg <= FETCH;
            end
          end
        end
        WB: begin
          if (wb_idx != '0) rf_reg[wb_idx] <= wb_data;
          state_reg <= FETCH;
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_multiciclo.sv
`timescale 1ns/1ps
// Instruction-level reference model driving a randomized program through the core over a
// wait-state memory; every cycle's bus/state outputs are checked against the model's expectation.
module tb_datapath_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready, illegal_o;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
  logic [2:0]  state_o;

  datapath_multiciclo #(.DATA_W(32), .NREG(32), .PC_RST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_o(pc_o),
    .state_o(state_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  logic [31:0] env_mem [1024];   // memory the DUT talks to
  logic [31:0] ref_mem [1024];   // model's own copy
  logic [31:0] ref_reg [32];
  logic [31:0] ref_pc;
  int vectors = 0, miscompares = 0, cyc_cnt = 0;
  int wait_mode = 0, wait_left = 0;
  bit busy = 1'b0, aborted = 1'b0;
  int lit_cyc [13] = '{4, 4, 4, 4, 4, 6, 7, 3, 3, 4, 2, 3, 2};

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    aborted = 1'b1;
    $display("FAIL %s: no completion within cycle budget, got none, expected mem_ready handshake", name);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
    cyc_cnt++;
  endtask

  // Memory responder: per-access wait count chosen when a request first appears.
  always @(negedge clk) begin
    if (rst_n && mem_req) begin
      if (!busy) begin
        busy = 1'b1;
        case (wait_mode)
          0:       wait_left = $urandom_range(0, 2);
          1:       wait_left = (state_o == 3'd3) ? 2 : 0;
          default: wait_left = (state_o == 3'd3) ? 100000 : 0;
        endcase
      end
      if (wait_left == 0) begin
        mem_ready = 1'b1;
        mem_rdata = env_mem[widx(mem_addr)];
        if (mem_we) env_mem[widx(mem_addr)] = mem_wdata;
        busy = 1'b0;
      end else begin
        wait_left--;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      busy      = 1'b0;
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    sel = $urandom_range(0, 99);
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    if (sel < 25)      return {6'h08, rs, rt, 16'($urandom)};
    else if (sel < 50) return {6'h00, rs, rt, rd, 5'd0, fn};
    else if (sel < 60) return {6'h23, 5'd0, rt, 16'h0800 + 16'(4 * $urandom_range(0, 255))};
    else if (sel < 70) return {6'h2B, 5'd0, rt, 16'h0800 + 16'(4 * $urandom_range(0, 255))};
    else if (sel < 80) return {6'h04, rs, rt, 16'($urandom_range(0, 8))};
    else if (sel < 87) return {6'h02, 26'($urandom_range(64, 511))};
    else if (sel < 91) return {6'h08, rs, 5'd0, 16'($urandom)};
    else if (sel < 95) return {(sel[0] ? 6'h3F : 6'h10), 26'($urandom)};
    else               return {6'h00, rs, rt, rd, 5'd0, 6'h3F};
  endfunction

  task automatic run_program(input int n, input int n_lit);
    for (int k = 0; k < n && !aborted; k++) begin
      int start, waits, base, guard;
      logic [31:0] ir, a, b, imm, res, ea, ipc;
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd, dst;
      bit op_ok, fn_ok, do_wb;
      if (k == n_lit && n_lit > 0) begin
        wait_mode = 0;
        check("pin_pc_after_j", pc_o, 32'h100);
        check("pin_r0", dut.rf_reg[0], 32'd0);
        check("pin_r1", dut.rf_reg[1], 32'd5);
        check("pin_r2", dut.rf_reg[2], 32'd7);
        check("pin_r3_add", dut.rf_reg[3], 32'd12);
        check("pin_r4_slt", dut.rf_reg[4], 32'd0);
        check("pin_r5_sub", dut.rf_reg[5], 32'hFFFF_FFFE);
        check("pin_r6_lw", dut.rf_reg[6], 32'd12);
        check("pin_mem8_sw", env_mem[2], 32'd12);
      end
      start = cyc_cnt; waits = 0; guard = 0; do_wb = 1'b0; dst = 5'd0; res = 32'd0; base = 0;
      ipc = ref_pc;
      while (1) begin
        check("fetch_state", 32'(state_o), 32'd0);
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_we", 32'(mem_we), 32'd0);
        check("fetch_addr", mem_addr, ref_pc);
        check("fetch_pc", pc_o, ref_pc);
        check("fetch_illegal", 32'(illegal_o), 32'd0);
        if (mem_ready === 1'b1) break;
        waits++; guard++;
        if (guard > 50) begin timeout_fail("fetch_timeout"); return; end
        step();
      end
      ir = ref_mem[widx(ref_pc)];
      ref_pc = ref_pc + 32'd4;
      step();
      op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11]; fn = ir[5:0];
      imm   = {{16{ir[15]}}, ir[15:0]};
      op_ok = (op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B});
      fn_ok = (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
      a = ref_reg[rs]; b = ref_reg[rt];
      check("dec_state", 32'(state_o), 32'd1);
      check("dec_req", 32'(mem_req), 32'd0);
      check("dec_illegal", 32'(illegal_o), 32'(!op_ok));
      check("dec_pc", pc_o, ref_pc);
      if (op == 6'h02) begin
        ref_pc = {ref_pc[31:28], ir[25:0], 2'b00};
        base = 2; step();
      end else if (!op_ok) begin
        base = 2; step();
      end else begin
        step();
        check("exec_state", 32'(state_o), 32'd2);
        check("exec_req", 32'(mem_req), 32'd0);
        check("exec_illegal", 32'(illegal_o), 32'(op == 6'h00 && !fn_ok));
        if (op == 6'h00 && !fn_ok) begin
          base = 3; step();
        end else if (op == 6'h04) begin
          if (a == b) ref_pc = ref_pc + (imm << 2);
          base = 3; step();
        end else if (op == 6'h23 || op == 6'h2B) begin
          ea = a + imm;
          step();
          guard = 0;
          while (1) begin
            check("mem_state", 32'(state_o), 32'd3);
            check("mem_req", 32'(mem_req), 32'd1);
            check("mem_we", 32'(mem_we), 32'(op == 6'h2B));
            check("mem_addr", mem_addr, ea);
            check("mem_wdata", mem_wdata, b);
            check("mem_illegal", 32'(illegal_o), 32'd0);
            if (mem_ready === 1'b1) break;
            waits++; guard++;
            if (guard > 50) begin timeout_fail("mem_timeout"); return; end
            step();
          end
          if (op == 6'h2B) begin
            ref_mem[widx(ea)] = b;
            base = 4; step();
          end else begin
            res = ref_mem[widx(ea)]; dst = rt; do_wb = 1'b1;
            base = 5; step();
          end
        end else begin
          if (op == 6'h08) begin
            res = a + imm; dst = rt;
          end else begin
            dst = rd;
            case (fn)
              6'h20:   res = a + b;
              6'h22:   res = a - b;
              6'h24:   res = a & b;
              6'h25:   res = a | b;
              default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
          end
          do_wb = 1'b1; base = 4; step();
        end
      end
      if (do_wb) begin
        check("wb_state", 32'(state_o), 32'd4);
        check("wb_req", 32'(mem_req), 32'd0);
        check("wb_illegal", 32'(illegal_o), 32'd0);
        if (dst != 5'd0) ref_reg[dst] = res;
        step();
      end
      check("instr_cycles", 32'(cyc_cnt - start), 32'((k < n_lit) ? lit_cyc[k] : base + waits));
      $display("instr %0d pc=%h ir=%h cycles=%0d waits=%0d", k, ipc, ir, cyc_cnt - start, waits);
    end
  endtask

  task automatic load_ref();
    for (int i = 0; i < 1024; i++) ref_mem[i] = env_mem[i];
    for (int i = 0; i < 32; i++) ref_reg[i] = 32'd0;
    ref_pc = 32'd0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pc", pc_o, 32'd0);

    // Reset while a lw is stalled in MEM.
    for (int i = 0; i < 1024; i++) env_mem[i] = $urandom;
    env_mem[0]   = {6'h08, 5'd0, 5'd7, 16'd3};
    env_mem[1]   = {6'h23, 5'd0, 5'd7, 16'h0800};
    env_mem[512] = 32'hDEAD_BEEF;
    load_ref();
    wait_mode = 2;
    release_reset();
    run_program(1, 0);
    guard = 0;
    while (state_o !== 3'd3 && guard < 20) begin step(); guard++; end
    check("abort_in_mem", 32'(state_o), 32'd3);
    step(); step();
    check("abort_waiting_req", 32'(mem_req), 32'd1);
    check("abort_r7_before", dut.rf_reg[7], 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_addr", mem_addr, 32'd0);
    check("abort_pc", pc_o, 32'd0);
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_r7", dut.rf_reg[7], 32'd0);
    repeat (2) @(posedge clk);
    check("abort_r7_held", dut.rf_reg[7], 32'd0);

    // Directed prologue followed by a random program.
    aborted = 1'b0;
    for (int i = 0; i < 1024; i++) env_mem[i] = $urandom;
    for (int i = 14; i < 512; i++) env_mem[i] = rand_instr();
    env_mem[0]  = {6'h08, 5'd0, 5'd1, 16'd5};             // addi $1,$0,5
    env_mem[1]  = {6'h08, 5'd0, 5'd2, 16'd7};             // addi $2,$0,7
    env_mem[2]  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; // add $3,$1,$2
    env_mem[3]  = {6'h00, 5'd2, 5'd1, 5'd4, 5'd0, 6'h2A}; // slt $4,$2,$1
    env_mem[4]  = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h22}; // sub $5,$1,$2
    env_mem[5]  = {6'h2B, 5'd0, 5'd3, 16'd8};             // sw $3,8($0)
    env_mem[6]  = {6'h23, 5'd0, 5'd6, 16'd8};             // lw $6,8($0)
    env_mem[7]  = {6'h04, 5'd1, 5'd2, 16'd5};             // beq $1,$2 (not taken)
    env_mem[8]  = {6'h04, 5'd1, 5'd1, 16'd1};             // beq $1,$1,+1 -> 0x28
    env_mem[9]  = {6'h3F, 26'd0};                         // skipped
    env_mem[10] = {6'h08, 5'd0, 5'd0, 16'd9};             // addi $0,$0,9
    env_mem[11] = {6'h3F, 26'h123};                       // illegal opcode
    env_mem[12] = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h3F}; // illegal funct
    env_mem[13] = {6'h02, 26'h40};                        // j 0x40 -> 0x100
    load_ref();
    wait_mode = 1;
    release_reset();
    run_program(600, 13);
    if (!aborted) begin
      for (int i = 0; i < 32; i++) check($sformatf("final_r%0d", i), dut.rf_reg[i], ref_reg[i]);
      for (int i = 512; i < 1024; i++) check($sformatf("final_mem%0d", i), env_mem[i], ref_mem[i]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
